// File: rtl/count_scan_display.sv
// Tracks changes of a 4-bit counter, keeps the last four distinct values, and
// scans them onto a 4-digit common-anode 7-segment display (newest on digit 0).
module count_scan_display #(
   parameter int SCAN_DIV       = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] q,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       change,
   output logic       wrap
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // Lit-segment pattern {a,b,c,d,e,f,g} for a hex digit, 1 = lit.
   function automatic logic [6:0] hex_font(input logic [3:0] val);
      logic [6:0] lit;
      case (val)
         4'h0: lit = 7'b1111110;
         4'h1: lit = 7'b0110000;
         4'h2: lit = 7'b1101101;
         4'h3: lit = 7'b1111001;
         4'h4: lit = 7'b0110011;
         4'h5: lit = 7'b1011011;
         4'h6: lit = 7'b1011111;
         4'h7: lit = 7'b1110000;
         4'h8: lit = 7'b1111111;
         4'h9: lit = 7'b1111011;
         4'hA: lit = 7'b1110111;
         4'hB: lit = 7'b0011111;
         4'hC: lit = 7'b1001110;
         4'hD: lit = 7'b0111101;
         4'hE: lit = 7'b1001111;
         default: lit = 7'b1000111;
      endcase
      return lit;
   endfunction

   function automatic logic [6:0] seg_drive(input logic [6:0] lit);
      return SEG_ACTIVE_LOW ? ~lit : lit;
   endfunction

   function automatic logic dp_drive(input logic lit);
      return SEG_ACTIVE_LOW ? ~lit : lit;
   endfunction

   logic [3:0]       q_d;
   logic [3:0]       h_val [4];
   logic             h_v   [4];
   logic             h_w   [4];
   logic [DIV_W-1:0] div;
   logic [1:0]       idx;

   logic             evt;
   logic             is_wrap;
   logic [3:0]       sel_val;
   logic             sel_v;
   logic             sel_w;

   assign evt     = (q != q_d);
   assign is_wrap = (q < q_d);
   assign sel_val = h_val[idx];
   assign sel_v   = h_v[idx];
   assign sel_w   = h_w[idx];

   // Sample stage: previous count, change/wrap strobes and value history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_d    <= 4'd0;
         change <= 1'b0;
         wrap   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            h_val[i] <= 4'd0;
            h_v[i]   <= 1'b0;
            h_w[i]   <= 1'b0;
         end
      end else begin
         q_d    <= q;
         change <= evt;
         wrap   <= evt & is_wrap;
         if (evt) begin
            for (int i = 3; i > 0; i--) begin
               h_val[i] <= h_val[i-1];
               h_v[i]   <= h_v[i-1];
               h_w[i]   <= h_w[i-1];
            end
            h_val[0] <= q;
            h_v[0]   <= 1'b1;
            h_w[0]   <= is_wrap;
         end
      end
   end

   // Scan stage: divider and digit index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div <= '0;
         idx <= 2'd0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         idx <= idx + 2'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Output stage: decode of the digit selected before this edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= seg_drive(7'h00);
         dp  <= dp_drive(1'b0);
         an  <= 4'b1110;
      end else begin
         an <= ~(4'b0001 << idx);
         if (sel_v) begin
            seg <= seg_drive(hex_font(sel_val));
            dp  <= dp_drive(sel_w);
         end else begin
            seg <= seg_drive(7'h00);
            dp  <= dp_drive(1'b0);
         end
      end
   end

endmodule

// File: tb/tb_count_scan_display.sv
// Directed bench for count_scan_display with SCAN_DIV=4, active-low segments.
module tb_count_scan_display;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] q;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       change;
   logic       wrap;

   int ncmp = 0;
   int nerr = 0;

   count_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .q(q), .seg(seg), .dp(dp),
      .an(an), .change(change), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] q;
      int         chg;
      int         wrp;
      logic [4:0] d0, d1, d2, d3;   // bit4 = valid, [3:0] = value
      logic [3:0] w;                // expected wrap mark per digit
   } vec_t;

   // Active-low patterns of the hex font, index = value
   logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   vec_t tv [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic [6:0] cap_seg [4];
      logic       cap_dp  [4];
      logic [4:0] dig     [4];
      int         nchg, nwrp, slot;
      nchg = 0;
      nwrp = 0;
      for (int i = 0; i < 4; i++) begin
         cap_seg[i] = 'x;
         cap_dp[i]  = 'x;
      end
      if (v.rst) begin
         reset = 1'b0;
         q = v.q;
         repeat (3) step();
         chk($sformatf("v%0d rst an", n), 32'(an), 32'(4'b1110));
         chk($sformatf("v%0d rst seg", n), 32'(seg), 32'(7'h7F));
         chk($sformatf("v%0d rst dp", n), 32'(dp), 32'd1);
         chk($sformatf("v%0d rst change", n), 32'(change), 32'd0);
         chk($sformatf("v%0d rst wrap", n), 32'(wrap), 32'd0);
         reset = 1'b1;
      end else begin
         q = v.q;
      end
      for (int c = 0; c < 20; c++) begin
         step();
         if (change) nchg++;
         if (wrap) nwrp++;
         case (an)
            4'b1110: slot = 0;
            4'b1101: slot = 1;
            4'b1011: slot = 2;
            4'b0111: slot = 3;
            default: slot = -1;
         endcase
         if (slot < 0) chk($sformatf("v%0d an onehot", n), 32'(an), 32'(4'b1110));
         else begin
            cap_seg[slot] = seg;
            cap_dp[slot]  = dp;
         end
      end
      chk($sformatf("v%0d change cycles", n), 32'(nchg), 32'(v.chg));
      chk($sformatf("v%0d wrap cycles", n), 32'(nwrp), 32'(v.wrp));
      dig[0] = v.d0; dig[1] = v.d1; dig[2] = v.d2; dig[3] = v.d3;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("v%0d digit%0d seg", n, i), 32'(cap_seg[i]),
             32'(dig[i][4] ? font[dig[i][3:0]] : 7'h7F));
         chk($sformatf("v%0d digit%0d dp", n, i), 32'(cap_dp[i]),
             32'((dig[i][4] && v.w[i]) ? 1'b0 : 1'b1));
      end
   endtask

   initial begin
      logic [3:0] prev_an;
      int         run;
      bit         started;
      bit         found;
      vec_t       tail;

      tv[0]  = '{1'b1, 4'h5, 1, 0, 5'h15, 5'h00, 5'h00, 5'h00, 4'b0000};
      tv[1]  = '{1'b1, 4'h0, 0, 0, 5'h00, 5'h00, 5'h00, 5'h00, 4'b0000};
      tv[2]  = '{1'b0, 4'h1, 1, 0, 5'h11, 5'h00, 5'h00, 5'h00, 4'b0000};
      tv[3]  = '{1'b0, 4'h2, 1, 0, 5'h12, 5'h11, 5'h00, 5'h00, 4'b0000};
      tv[4]  = '{1'b0, 4'h9, 1, 0, 5'h19, 5'h12, 5'h11, 5'h00, 4'b0000};
      tv[5]  = '{1'b0, 4'h0, 1, 1, 5'h10, 5'h19, 5'h12, 5'h11, 4'b0001};
      tv[6]  = '{1'b0, 4'h0, 0, 0, 5'h10, 5'h19, 5'h12, 5'h11, 4'b0001};
      tv[7]  = '{1'b0, 4'h3, 1, 0, 5'h13, 5'h10, 5'h19, 5'h12, 4'b0010};
      tv[8]  = '{1'b0, 4'h4, 1, 0, 5'h14, 5'h13, 5'h10, 5'h19, 4'b0100};
      tv[9]  = '{1'b0, 4'h5, 1, 0, 5'h15, 5'h14, 5'h13, 5'h10, 4'b1000};
      tv[10] = '{1'b0, 4'hF, 1, 0, 5'h1F, 5'h15, 5'h14, 5'h13, 4'b0000};
      tv[11] = '{1'b0, 4'hA, 1, 1, 5'h1A, 5'h1F, 5'h15, 5'h14, 4'b0001};
      tv[12] = '{1'b0, 4'hB, 1, 0, 5'h1B, 5'h1A, 5'h1F, 5'h15, 4'b0010};
      tv[13] = '{1'b0, 4'hC, 1, 0, 5'h1C, 5'h1B, 5'h1A, 5'h1F, 4'b0100};
      tv[14] = '{1'b0, 4'hD, 1, 0, 5'h1D, 5'h1C, 5'h1B, 5'h1A, 4'b1000};
      tv[15] = '{1'b0, 4'hE, 1, 0, 5'h1E, 5'h1D, 5'h1C, 5'h1B, 4'b0000};
      tv[16] = '{1'b0, 4'h6, 1, 1, 5'h16, 5'h1E, 5'h1D, 5'h1C, 4'b0001};
      tv[17] = '{1'b0, 4'h7, 1, 0, 5'h17, 5'h16, 5'h1E, 5'h1D, 4'b0010};
      tv[18] = '{1'b0, 4'h8, 1, 0, 5'h18, 5'h17, 5'h16, 5'h1E, 4'b0100};

      reset = 1'b0;
      q = 4'h0;
      #2;
      for (int i = 0; i < 19; i++) run_vec(i, tv[i]);

      // q changing on every edge: one change pulse per edge, none lost
      for (int i = 0; i < 4; i++) begin
         q = 4'h9 + 4'(i);
         step();
         chk($sformatf("b2b change %0d", i), 32'(change), 32'd1);
         chk($sformatf("b2b wrap %0d", i), 32'(wrap), 32'd0);
      end
      step();
      chk("b2b change end", 32'(change), 32'd0);
      tail = '{1'b0, 4'hC, 0, 0, 5'h1C, 5'h1B, 5'h1A, 5'h19, 4'b0000};
      run_vec(100, tail);

      // Constant q: digit enables rotate, each held exactly four cycles
      prev_an = an;
      run = 0;
      started = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         chk("rot change", 32'(change), 32'd0);
         if (an == prev_an) run++;
         else begin
            chk("rot next an", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
            if (started) chk("rot hold", 32'(run), 32'd4);
            started = 1'b1;
            run = 1;
            prev_an = an;
         end
      end

      // Asynchronous reset between edges while digit 2 is enabled
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (an == 4'b1011) found = 1'b1;
      end
      chk("find an 1011", 32'(an), 32'(4'b1011));
      #2;
      q = 4'h0;
      reset = 1'b0;
      #1;
      chk("async an", 32'(an), 32'(4'b1110));
      chk("async seg", 32'(seg), 32'(7'h7F));
      chk("async dp", 32'(dp), 32'd1);
      step();
      step();
      reset = 1'b1;
      tail = '{1'b0, 4'h0, 0, 0, 5'h00, 5'h00, 5'h00, 5'h00, 4'b0000};
      run_vec(200, tail);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/count_scan_display.md
# count_scan_display

Downstream consumer of the 4-bit synchronous counter value `q`. It detects every change of the count, keeps the last four distinct values, and drives a 4-digit multiplexed common-anode 7-segment display. The display shows the newest value on digit 0 and older values on digits 1–3, with the decimal point marking values entered by a wrap-around. The block sits between the counter and the board display pins, and also gives one-cycle `change` and `wrap` strobes to any logic that needs them.

## Interface
- `SCAN_DIV`, 16, clock cycles each digit stays enabled; legal range ≥2.
- `SEG_ACTIVE_LOW`, 1, 1: `seg`/`dp` bit = 0 lights a segment; 0: bit = 1 lights it. `an` is always active-low.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `q` in 4: counter value, synchronous to `clk`.
- `seg` out 7: segments, `seg[6:0]` = {a,b,c,d,e,f,g}.
- `dp` out 1: decimal point.
- `an` out 4: digit enables, one-hot active-low, `an[0]` = digit 0.
- `change` out 1: one-cycle pulse when the sampled `q` differs from the previous sample.
- `wrap` out 1: one-cycle pulse when the new `q` is numerically less than the previous sample.

## Operation
- **Sampling**
  - `q_d <= q` every cycle.
  - New event when `q != q_d`, evaluated at the same edge.
- **History**
  - Four entries h0..h3, each holding a 4-bit value, a valid bit `v` and a wrap bit `w`.
  - On an event: shift h3←h2←h1←h0, then h0 ← {q, v=1, w=(q<q_d)}.
  - No event: the history holds.
  - Wrap detection uses unsigned 4-bit compare only; 15→0 and 9→0 both count as wrap.
- **Strobes**
  - `change <= event`.
  - `wrap <= event & (q<q_d)`.
- **Scan**
  - Divider `div` counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, `div` returns to 0 and digit index `idx` advances 0→1→2→3→0.
- **Decode of digit `idx`**
  - If `v`=0 the digit is blank: all segments and `dp` are off, but `an` is still driven.
  - Otherwise hex segments, listed as lit segments:
    - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
    - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
    - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
    - C adef, d bcdeg, E adefg, F aefg
  - `dp` is lit iff `w`=1.
- **Output polarity**
  - With SEG_ACTIVE_LOW=1, an off segment is 1.
  - `an = ~(4'b0001 << idx)`.
- **Reset values** (applied immediately, independent of `clk`)
  - `q_d`=0, all history entries cleared (v=0, w=0, value 0).
  - `div`=0, `idx`=0.
  - `an`=4'b1110, `seg` all off (7'h7F when active-low), `dp` off (1 when active-low).
  - `change`=0, `wrap`=0.
- **Entry condition**
  - Because `q_d` resets to 0, the first post-reset `q` of 0 is not an event.
  - Any nonzero first sample is an event with no wrap.

## Timing
- `change` and `wrap` are registered.
  - For `q` first sampled at edge k, the pulse is high from edge k to edge k+1.
  - Back-to-back changes give back-to-back pulses.
- `seg`, `an` and `dp` are registered from the current `idx` and history, so they lag state by one cycle.
  - A history update at edge k is visible on `seg` after edge k+1 if that digit is selected.
- Each `an` value is held exactly SCAN_DIV cycles, giving a full refresh every 4·SCAN_DIV cycles.
- Simultaneous event and scan advance at the same edge: both take effect; the decode uses the post-edge state at the next edge.
- Reset asserted mid-scan or mid-pulse:
  - outputs go to reset values without waiting for `clk`;
  - after deassertion, scanning restarts at digit 0 with `div`=0 on the first edge.
- `q` changing every cycle: every edge is an event, the history shifts each cycle, and no event is lost.

## Test plan
All scenarios use SCAN_DIV=4 and SEG_ACTIVE_LOW=1.
- **Reset**: hold reset=0 for 3 cycles with q=5 → `an`=1110, `seg`=7'h7F, `dp`=1, `change`=0, `wrap`=0. Release → first edge gives `change`=1 for exactly one cycle, and digit 0 then shows 5 (`seg`=7'b0100100).
- **Increment**: q steps 0→1→2, holding each for 10 cycles → two `change` pulses and no `wrap`. In the digit-0 slot `seg`=7'b0010010 (2); digit 1 shows 7'b1001111 (1); digits 2 and 3 show 7'h7F.
- **Wrap**: q 9→0 → `wrap` and `change` both pulse one cycle. In the digit-0 slot `seg`=7'b0000001 and `dp`=0; digit 1 shows 9 (7'b0000100) with `dp`=1.
- **Scan rotation**: constant q for 40 cycles → `an` cycles 1110, 1101, 1011, 0111, each for 4 cycles, then repeats; no `change` pulses.
- **History overflow**: events 1,2,3,4,5 → digits 0..3 show 5,4,3,2 and value 1 is discarded.
- **Async reset mid-scan**: assert reset between edges while `an`=1011 → `an`=1110, `seg`=7'h7F and `dp`=1 immediately; after release, all digits stay blank until the next event.
